// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus of fifo_wr_arbiter: requester handshakes, FIFO write port and status.
// FIFO_WR_ARB_CHAN_TAG_EN widens wr_data to {channel index, sample}.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 12
);
  localparam int CH_BITS = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
`ifdef FIFO_WR_ARB_CHAN_TAG_EN
  localparam int WR_W = DATA_WIDTH + CH_BITS;
`else
  localparam int WR_W = DATA_WIDTH;
`endif

  // A sample moves on a clk edge where req_valid[i] && req_ready[i]; a FIFO word
  // moves on a clk edge where wr_en is high; wr_en never asserts while wr_full is high.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wr_full;
  logic                          wr_en;
  logic [WR_W-1:0]               wr_data;
  logic [CH_BITS-1:0]            grant_id;
  logic                          stall_err;

  modport master (
    input  req_valid, req_data, wr_full,
    output req_ready, wr_en, wr_data, grant_id, stall_err
  );

  modport slave (
    output req_valid, req_data, wr_full,
    input  req_ready, wr_en, wr_data, grant_id, stall_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port, with a one-word output register and
// a sticky stall monitor. Define FIFO_WR_ARB_CHAN_TAG_EN to prefix each word with its channel index.
module fifo_wr_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 12,
  parameter int STALL_LIMIT = 64
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int CH_BITS = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
`ifdef FIFO_WR_ARB_CHAN_TAG_EN
  localparam int WR_W = DATA_WIDTH + CH_BITS;
`else
  localparam int WR_W = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  logic                  r_out_valid;
  logic [WR_W-1:0]       r_wr_data;
  logic [CH_BITS-1:0]    r_grant_id;
  logic [CH_BITS-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic                  r_stall_err;

  logic                  w_wr_en;
  logic                  w_load_ok;
  logic                  w_found;
  logic                  w_accept;
  logic                  w_stall;
  logic [CH_BITS-1:0]    w_gnt;
  logic [CH_BITS-1:0]    w_rr_next;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [NUM_REQ-1:0]    w_req_ready;
  int                    w_idx;

  assign w_wr_en   = r_out_valid && !bus.wr_full;
  assign w_load_ok = !r_out_valid || w_wr_en;
  assign w_stall   = r_out_valid && bus.wr_full;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = CH_BITS'(w_idx);
      end
    end
  end

  assign w_accept   = w_load_ok && w_found && !rst;
  assign w_gnt_data = bus.req_data[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign w_rr_next  = (w_gnt == CH_BITS'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

  always_comb begin
    w_req_ready = '0;
    if (w_accept) w_req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_wr_data   <= '0;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
`ifdef FIFO_WR_ARB_CHAN_TAG_EN
      r_wr_data   <= {w_gnt, w_gnt_data};
`else
      r_wr_data   <= w_gnt_data;
`endif
      r_grant_id  <= w_gnt;
      r_rr_ptr    <= w_rr_next;
    end else if (w_wr_en) begin
      r_out_valid <= 1'b0;
    end
  end

  // The error latches on the edge where the counter reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else if (w_stall) begin
      if (r_stall_cnt != CNT_W'(STALL_LIMIT)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (r_stall_cnt == CNT_W'(STALL_LIMIT - 1)) r_stall_err <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_data   = r_wr_data;
  assign bus.grant_id  = r_grant_id;
  assign bus.stall_err = r_stall_err;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level model with a word scoreboard.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int DATA_WIDTH  = 12;
  localparam int STALL_LIMIT = 64;
  localparam int CH_BITS     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
`ifdef FIFO_WR_ARB_CHAN_TAG_EN
  localparam int WR_W = DATA_WIDTH + CH_BITS;
`else
  localparam int WR_W = DATA_WIDTH;
`endif

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bench-side requesters and reference model
  logic [NUM_REQ-1:0]    pend;
  logic [DATA_WIDTH-1:0] smp [NUM_REQ];
  logic [WR_W-1:0]       exp_q [$];
  bit                    m_hold;
  int                    m_gid;
  int                    m_ptr;
  int                    m_run;
  bit                    m_err;
  int                    n_checks;
  int                    n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hold = 0;
    m_gid  = 0;
    m_ptr  = 0;
    m_run  = 0;
    m_err  = 0;
    exp_q.delete();
  endtask

  task automatic drive_bus(input logic [NUM_REQ-1:0] mask, input logic full);
    bus.req_valid = pend & mask;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = smp[i];
    bus.wr_full = full;
  endtask

  // Check outputs at mid-cycle, then advance the model across the coming edge.
  task automatic check_and_step();
    bit                 exp_en;
    bit                 load_ok;
    bit                 found;
    int                 g;
    int                 idx;
    logic [NUM_REQ-1:0] exp_ready;
    logic [WR_W-1:0]    word;
    exp_en  = m_hold && !bus.wr_full;
    load_ok = !m_hold || exp_en;
    found   = 0;
    g       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1;
        g     = idx;
      end
    end
    exp_ready = '0;
    if (load_ok && found) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("wr_en", 32'(bus.wr_en), 32'(exp_en));
    chk("stall_err", 32'(bus.stall_err), 32'(m_err));
    if (m_hold) chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    if (exp_en && exp_q.size() > 0) begin
      word = exp_q.pop_front();
      chk("wr_data", 32'(bus.wr_data), 32'(word));
    end
    if (m_hold && bus.wr_full) begin
      m_run++;
      if (m_run >= STALL_LIMIT) m_err = 1;
    end else begin
      m_run = 0;
    end
    if (load_ok && found) begin
`ifdef FIFO_WR_ARB_CHAN_TAG_EN
      word = {CH_BITS'(g), smp[g]};
`else
      word = smp[g];
`endif
      exp_q.push_back(word);
      m_hold  = 1;
      m_gid   = g;
      m_ptr   = (g + 1) % NUM_REQ;
      pend[g] = 1'b0;
      smp[g]  = smp[g] + 1'b1;
    end else if (exp_en) begin
      m_hold = 0;
    end
  endtask

  // driver: one clock cycle of stimulus
  task automatic cycle(input int pct, input logic [NUM_REQ-1:0] mask, input logic full);
    for (int i = 0; i < NUM_REQ; i++)
      if (mask[i] && !pend[i] && $urandom_range(0, 99) < pct) pend[i] = 1'b1;
    drive_bus(mask, full);
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    pend = '1;
    drive_bus('1, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_stall_err", 32'(bus.stall_err), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pend     = '0;
    for (int i = 0; i < NUM_REQ; i++) smp[i] = DATA_WIDTH'(i << 11);
    model_clear();
    rst = 1'b1;
    drive_bus('1, 1'b0);
    @(posedge clk);
    #1;
    do_reset(3);

    // rotation, no backpressure
    for (int c = 0; c < 20; c++) cycle(100, '1, 1'b0);
    // backpressure mid-stream, then recovery
    for (int c = 0; c < 10; c++) cycle(100, '1, 1'b1);
    for (int c = 0; c < 10; c++) cycle(100, '1, 1'b0);
    // single requester pulsing every third cycle
    for (int c = 0; c < 30; c++) cycle((c % 3 == 0) ? 100 : 0, 2'b10, 1'b0);
    // prolonged stall, then clear wr_full: error must stay sticky
    cycle(100, '1, 1'b0);
    for (int c = 0; c < 70; c++) cycle(100, '1, 1'b1);
    for (int c = 0; c < 6; c++) cycle(100, '1, 1'b0);
    do_reset(3);

    // random traffic with a reset dropped in mid-operation
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset(2);
      cycle($urandom_range(20, 100), '1, $urandom_range(0, 99) < 30);
    end
    // drain
    for (int c = 0; c < 8; c++) cycle(0, '1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the clock-domain-crossing FIFO (async_fifo, write side) between NUM_REQ audio sample producers, e.g. left/right ADC channels or a test-tone generator.
- Round-robin grant with a one-word output register, so the FIFO's wr_en/wr_data are driven from flops.
- Honours wr_full backpressure and flags prolonged stalls.
- Sits entirely in the FIFO write-clock domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 12, sample width per requester.
- STALL_LIMIT, 64, consecutive cycles of (out_valid && wr_full) after which stall_err sets.

Ports:
- clk  in  1  write-domain clock (connects to FIFO wr_clk).
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed samples; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept strobe; a sample transfers when req_valid[i] && req_ready[i].
- wr_full  in  1  FIFO full flag.
- wr_en  out  1  FIFO write enable.
- wr_data  out  DATA_WIDTH (+CH_BITS with tag option)  FIFO write data.
- grant_id  out  CH_BITS  index of the requester whose word is in the output register; CH_BITS = max(1, clog2(NUM_REQ)).
- stall_err  out  1  sticky stall flag.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out_valid=0, wr_data=0, grant_id=0, rr_ptr=0, stall_cnt=0, stall_err=0.
  - wr_en=0 and req_ready=0 while rst is high.
- Output stage:
  - out_valid flop marks the output register as full.
  - wr_en = out_valid && !wr_full (combinational from the wr_full input only).
  - A word is written to the FIFO on every clk edge where wr_en=1.
- Load condition: load_ok = !out_valid || wr_en. This allows back-to-back, one word per cycle, when the FIFO is not full.
- Arbitration (combinational, same cycle):
  - When load_ok, search req_valid starting at rr_ptr, ascending with wrap, and pick the first set bit, g.
  - req_ready[g]=1; all other req_ready bits are 0.
  - No valid requester, or !load_ok, gives req_ready=0.
- Register update on an accept:
  - wr_data <= req_data[g]; grant_id <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0.
- wr_en=1 with no accept: out_valid <= 0; wr_data and grant_id hold.
- Latency: sample accepted at edge N, wr_en can assert in the cycle after edge N.
- Fairness: with all requesters continuously valid and no backpressure, grants rotate 0,1,..,NUM_REQ-1,0,... A requester waits at most NUM_REQ-1 grants.
- Full FIFO:
  - Output register holds, req_ready=0 for all requesters, rr_ptr frozen.
  - No word is ever lost or duplicated.
- Simultaneous drain and load: when wr_en=1 and a requester is valid in the same cycle, the write and the accept happen on the same edge.
- Stall monitor:
  - stall_cnt increments while out_valid && wr_full, saturating at STALL_LIMIT.
  - stall_cnt clears on any cycle where that condition is false.
  - stall_err sets when stall_cnt reaches STALL_LIMIT and clears only on rst.
- Reset mid-operation: a pending word in the output register is discarded; no wr_en pulse occurs during or after reset until a new accept.
- req_data is sampled only on accept. Requesters must hold req_data stable while req_valid=1 and req_ready=0.

Optional Feature:
- Macro: FIFO_WR_ARB_CHAN_TAG_EN.
- Defined:
  - wr_data is DATA_WIDTH+CH_BITS wide = {grant index, sample}, index in the MSBs.
  - The FIFO must be instantiated with DATA_WIDTH+CH_BITS.
  - The read side demultiplexes channels from the tag.
- Undefined:
  - wr_data is DATA_WIDTH wide, sample only.
  - Channel order is implied by the strict rotation and must be reconstructed by the consumer.
- grant_id is present in both builds.

Test Plan:
- Reset: hold rst high 3 cycles with req_valid=2'b11 → req_ready=0, wr_en=0, stall_err=0, wr_data=0.
- Rotation: NUM_REQ=2, both valid continuously, req0 counting 0x000,0x001,..., req1 counting 0x800,0x801,..., wr_full=0 → wr_en high every cycle from the 2nd cycle on; wr_data sequence 0x000,0x800,0x001,0x801,...; grant_id alternates 0,1.
- Backpressure: force wr_full=1 for 10 cycles mid-stream → wr_en=0, req_ready=0, wr_data frozen. After wr_full drops, the held word is written exactly once and rotation resumes at the next requester.
- Single requester: only req1 valid, pulsing every 3rd cycle → each sample appears on wr_data one cycle after its accept with grant_id=1; req0 never readied.
- Stall: STALL_LIMIT=64, wr_full held high 70 cycles with out_valid=1 → stall_err rises after 64 stalled cycles and stays set after wr_full clears until rst.
- System: connect to async_fifo (ADDR_WIDTH=3, wr clk 10 ns, rd clk 46 ns), tag option defined → read-side stream per tag is gap-free and in order for 40 µs.
